// File: rtl/elm_pkg.sv
// Shared types and defaults for the ELM hidden-layer sequencer.
// State encoding is also exposed on the sequencer's debug port.
package elm_pkg;
    localparam int IN_W_DEF  = 4;
    localparam int HID_W_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MAC  = 3'd2,
        S_BIAS = 3'd3,
        S_ACT  = 3'd4,
        S_WAIT = 3'd5,
        S_WB   = 3'd6,
        S_DONE = 3'd7
    } seq_state_t;
endpackage

// File: rtl/elm_hidden_seq_if.sv
// Bundle between the hidden-layer sequencer (master) and its control/datapath peers (slave).
// res_valid/res_ready: a result transfers on a cycle where both are high; once raised,
// res_valid and hid_idx stay stable until that transfer, and valid never waits on ready.
interface elm_hidden_seq_if #(
    parameter int IN_W  = 4,
    parameter int HID_W = 6
);
    logic             start;
    logic [IN_W-1:0]  cfg_n_in;
    logic [HID_W-1:0] cfg_n_hid;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  in_idx;
    logic [HID_W-1:0] hid_idx;
    logic             acc_clr;
    logic             mac_en;
    logic             bias_en;
    logic             act_start;
    logic             act_valid;
    logic             res_valid;
    logic             res_ready;

    modport master (
        input  start, cfg_n_in, cfg_n_hid, act_valid, res_ready,
        output busy, done, in_idx, hid_idx, acc_clr, mac_en, bias_en, act_start, res_valid
    );

    modport slave (
        output start, cfg_n_in, cfg_n_hid, act_valid, res_ready,
        input  busy, done, in_idx, hid_idx, acc_clr, mac_en, bias_en, act_start, res_valid
    );
endinterface

// File: rtl/elm_idx_counter.sv
// Index counter: synchronous clear has priority over enable; tc flags cnt == last.
module elm_idx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == last);
endmodule

// File: rtl/elm_hidden_seq.sv
// ELM hidden-layer sequencer: inputs are the inner loop, neurons the outer loop.
// Define ELM_SEQ_BIAS_EN to add a one-cycle bias-add step after each neuron's MAC run.
module elm_hidden_seq
    import elm_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int HID_W = HID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    elm_hidden_seq_if.master bus,
    output seq_state_t       dbg_state
);
    localparam logic [IN_W-1:0]  IN_ONE  = 1;
    localparam logic [HID_W-1:0] HID_ONE = 1;

    seq_state_t       state;
    logic [IN_W-1:0]  n_in_q;
    logic [HID_W-1:0] n_hid_q;
    logic             in_tc;
    logic             hid_tc;
    logic             in_clr;
    logic             in_en;
    logic             hid_clr;
    logic             hid_en;
    logic             res_fire;

    assign res_fire  = (state == S_WB) && bus.res_ready;
    assign dbg_state = state;

    // in_idx is only meaningful in MAC/BIAS, so it sits at 0 everywhere else.
    assign in_clr = (state != S_MAC);
`ifdef ELM_SEQ_BIAS_EN
    // One step past the last input lands on the bias column.
    assign in_en = (state == S_MAC);
`else
    assign in_en = (state == S_MAC) && !in_tc;
`endif
    assign hid_clr = (state == S_IDLE) || (state == S_DONE);
    assign hid_en  = res_fire && !hid_tc;

    elm_idx_counter #(.W(IN_W)) u_in_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_clr),
        .en   (in_en),
        .last (n_in_q - IN_ONE),
        .cnt  (bus.in_idx),
        .tc   (in_tc)
    );

    elm_idx_counter #(.W(HID_W)) u_hid_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (hid_clr),
        .en   (hid_en),
        .last (n_hid_q - HID_ONE),
        .cnt  (bus.hid_idx),
        .tc   (hid_tc)
    );

`ifdef ELM_SEQ_BIAS_EN
    logic bias_q;
    assign bus.bias_en = bias_q;
`else
    assign bus.bias_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            n_in_q        <= '0;
            n_hid_q       <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.act_start <= 1'b0;
            bus.res_valid <= 1'b0;
`ifdef ELM_SEQ_BIAS_EN
            bias_q        <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low; mac_en/res_valid/busy are held explicitly.
            bus.done      <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.act_start <= 1'b0;
`ifdef ELM_SEQ_BIAS_EN
            bias_q        <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_n_in != '0 && bus.cfg_n_hid != '0) begin
                            state       <= S_CLR;
                            n_in_q      <= bus.cfg_n_in;
                            n_hid_q     <= bus.cfg_n_hid;
                            bus.busy    <= 1'b1;
                            bus.acc_clr <= 1'b1;
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    state      <= S_MAC;
                    bus.mac_en <= 1'b1;
                end
                S_MAC: begin
                    if (in_tc) begin
                        bus.mac_en <= 1'b0;
`ifdef ELM_SEQ_BIAS_EN
                        state  <= S_BIAS;
                        bias_q <= 1'b1;
`else
                        state         <= S_ACT;
                        bus.act_start <= 1'b1;
`endif
                    end
                end
`ifdef ELM_SEQ_BIAS_EN
                S_BIAS: begin
                    state         <= S_ACT;
                    bus.act_start <= 1'b1;
                end
`endif
                S_ACT: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.act_valid) begin
                        state         <= S_WB;
                        bus.res_valid <= 1'b1;
                    end
                end
                S_WB: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (hid_tc) begin
                            state    <= S_DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= S_CLR;
                            bus.acc_clr <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elm_hidden_seq.sv
// Self-checking bench for elm_hidden_seq: vector table, randomized runs and hand-written
// reset sequence, all checked against an event-list model of the loop nest.
module tb_elm_hidden_seq;
    import elm_pkg::*;

`ifdef ELM_SEQ_BIAS_EN
    localparam int HAS_BIAS = 1;
`else
    localparam int HAS_BIAS = 0;
`endif

    localparam int EV_W    = 13;
    localparam int EV_CLR  = 1;
    localparam int EV_MAC  = 2;
    localparam int EV_BIAS = 3;
    localparam int EV_ACT  = 4;
    localparam int EV_WB   = 5;
    localparam int EV_DONE = 6;

    typedef logic [EV_W-1:0] ev_t;

    typedef struct {
        int n_in;
        int n_hid;
        int lat;
        int stall;
        bit noise;
        bit repulse;
        int base_cycles;
    } vec_t;

    logic       clk;
    logic       rst;
    seq_state_t dbg_state;

    elm_hidden_seq_if #(.IN_W(4), .HID_W(6)) bus ();

    elm_hidden_seq #(.IN_W(4), .HID_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int  checks;
    int  failures;
    int  bias_seen;
    int  bias_exp;
    logic [EV_W-1:0] exp_q[$];

    function automatic ev_t mk_ev(input int kind, input int hid, input int idx);
        return {3'(kind), 6'(hid), 4'(idx)};
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic obs(input ev_t got, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s extra_event got=%h", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s event got=%h exp=%h", name, got, e);
            end
        end
    endtask

    task automatic sample_events(input string name);
        if (bus.acc_clr)   obs(mk_ev(EV_CLR, bus.hid_idx, bus.in_idx), name);
        if (bus.mac_en)    obs(mk_ev(EV_MAC, bus.hid_idx, bus.in_idx), name);
        if (bus.bias_en) begin
            bias_seen++;
            obs(mk_ev(EV_BIAS, bus.hid_idx, bus.in_idx), name);
        end
        if (bus.act_start) obs(mk_ev(EV_ACT, bus.hid_idx, 0), name);
    endtask

    function automatic int outputs_word();
        return int'({bus.busy, bus.done, bus.in_idx, bus.hid_idx, bus.acc_clr, bus.mac_en,
                     bus.bias_en, bus.act_start, bus.res_valid, dbg_state});
    endfunction

    // Runs one job; expected behaviour is the loop nest written out as an event list.
    task automatic run_job(input int n_in, input int n_hid, input int lat, input int stall,
                           input bit noise, input bit repulse, input int exp_total,
                           input string name);
        int  k;
        bit  done_seen;
        bit  pend;
        int  cnt;
        int  stall_left;
        int  h_cur;
        int  rv_cycles;
        int  proto_err;
        int  budget;
        bit  active;

        active = (n_in != 0) && (n_hid != 0);
        exp_q.delete();
        if (active) begin
            for (int h = 0; h < n_hid; h++) begin
                exp_q.push_back(mk_ev(EV_CLR, h, 0));
                for (int i = 0; i < n_in; i++) exp_q.push_back(mk_ev(EV_MAC, h, i));
                if (HAS_BIAS != 0) exp_q.push_back(mk_ev(EV_BIAS, h, n_in));
                exp_q.push_back(mk_ev(EV_ACT, h, 0));
                exp_q.push_back(mk_ev(EV_WB, h, 0));
            end
            bias_exp += HAS_BIAS * n_hid;
        end
        exp_q.push_back(mk_ev(EV_DONE, 0, 0));

        @(negedge clk);
        bus.start     = 1'b1;
        bus.cfg_n_in  = 4'(n_in);
        bus.cfg_n_hid = 6'(n_hid);
        bus.act_valid = 1'b0;
        bus.res_ready = 1'b0;
        k = 0; done_seen = 0; pend = 0; cnt = 0; stall_left = stall;
        h_cur = 0; rv_cycles = 0; proto_err = 0;
        budget = exp_total + 200;

        while (!done_seen && k < budget) begin
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            if (noise) begin
                bus.cfg_n_in  = 4'($urandom);
                bus.cfg_n_hid = 6'($urandom);
            end
            if (repulse && k < exp_total && $urandom_range(0, 3) == 0) bus.start = 1'b1;
            if (bus.busy !== (k <= exp_total)) proto_err++;

            if (bus.res_valid === 1'b1) begin
                rv_cycles++;
                if (bus.hid_idx != h_cur) proto_err++;
                if (stall_left > 0) begin
                    bus.res_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.res_ready = 1'b1;
                end
            end else begin
                bus.res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (bus.act_start === 1'b1) begin
                pend = 1; cnt = lat; bus.act_valid = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.act_valid = 1'b1;
                    pend = 0;
                end else begin
                    bus.act_valid = 1'b0;
                end
            end else begin
                bus.act_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            sample_events(name);
            if (bus.res_valid && bus.res_ready) begin
                obs(mk_ev(EV_WB, bus.hid_idx, 0), name);
                h_cur++;
                stall_left = stall;
            end
            if (bus.done) begin
                obs(mk_ev(EV_DONE, 0, 0), name);
                done_seen = 1;
                check_int({name, " done_cycle"}, k, exp_total + 1);
            end
        end

        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout no done after %0d cycles", name, k);
        end

        bus.start = 1'b0; bus.act_valid = 1'b0; bus.res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.busy || bus.res_valid) proto_err++;
            sample_events(name);
            if (bus.done) obs(mk_ev(EV_DONE, 0, 0), name);
        end

        check_int({name, " events_left"}, exp_q.size(), 0);
        check_int({name, " busy_hold_errors"}, proto_err, 0);
        check_int({name, " res_valid_cycles"}, rv_cycles, active ? n_hid * (stall + 1) : 0);
    endtask

    vec_t tbl[8];

    initial begin
        int total;
        int ni, nh, lt, st;
        bit found;

        checks = 0; failures = 0; bias_seen = 0; bias_exp = 0;
        tbl[0] = '{3,  2,  2, 0, 1'b0, 1'b0, 16};
        tbl[1] = '{2,  1,  1, 5, 1'b0, 1'b0, 11};
        tbl[2] = '{0,  4,  1, 0, 1'b0, 1'b0, 0};
        tbl[3] = '{5,  0,  1, 0, 1'b0, 1'b0, 0};
        tbl[4] = '{1,  1,  1, 0, 1'b0, 1'b0, 5};
        tbl[5] = '{15, 1,  3, 0, 1'b0, 1'b0, 21};
        tbl[6] = '{4,  3,  1, 2, 1'b1, 1'b1, 30};
        tbl[7] = '{15, 63, 1, 0, 1'b0, 1'b0, 1197};

        rst = 1'b0;
        bus.start = 1'b0; bus.cfg_n_in = '0; bus.cfg_n_hid = '0;
        bus.act_valid = 1'b0; bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_int("reset_outputs_in_reset", outputs_word(), 0);
        rst = 1'b1;
        @(negedge clk);
        check_int("reset_outputs_after_release", outputs_word(), 0);

        for (int v = 0; v < 8; v++) begin
            total = tbl[v].base_cycles + ((tbl[v].base_cycles != 0) ? HAS_BIAS * tbl[v].n_hid : 0);
            run_job(tbl[v].n_in, tbl[v].n_hid, tbl[v].lat, tbl[v].stall,
                    tbl[v].noise, tbl[v].repulse, total, $sformatf("vec%0d", v));
        end

        // Reset while neuron 1 is in its MAC phase.
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_n_in = 4'd4; bus.cfg_n_hid = 6'd3;
        bus.act_valid = 1'b1; bus.res_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.mac_en && bus.hid_idx == 6'd1) found = 1;
        end
        check_int("rst_reached_mac_n1", int'(found), 1);
        #2 rst = 1'b0;
        #1 check_int("rst_outputs_same_cycle", outputs_word(), 0);
        @(negedge clk);
        check_int("rst_outputs_held", outputs_word(), 0);
        rst = 1'b1;
        bus.act_valid = 1'b0; bus.res_ready = 1'b0;
        run_job(2, 2, 1, 1, 1'b0, 1'b0, 2 * (5 + 2 + HAS_BIAS), "after_rst");

        for (int r = 0; r < 10; r++) begin
            ni = $urandom_range(0, 15);
            nh = $urandom_range(0, 5);
            lt = $urandom_range(1, 4);
            st = $urandom_range(0, 3);
            total = (ni == 0 || nh == 0) ? 0 : nh * (3 + ni + HAS_BIAS + lt + st);
            run_job(ni, nh, lt, st, 1'b1, 1'($urandom_range(0, 1)), total,
                    $sformatf("rand%0d", r));
        end

        check_int("bias_strobe_count", bias_seen, bias_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
